// File: rtl/RV32I_pkg.sv
`default_nettype none
// ============================================================================
// Module      : RV32I_pkg
// Description : Shared definitions for the RV32I execute stage. It holds the
//               ALU op codes that the iterative divider consumes and the
//               divider state enum.
// Contents    : ALU_DIV, ALU_MOD   - decoder op codes (div, mod)
//               div_state_t        - divider FSM states
//               is_div_op()        - true for op codes the divider accepts
// Revision    : 1.0 - initial release
// ============================================================================
package RV32I_pkg;

   // These must match the ALU decoder encoding exactly.
   localparam logic [3:0] ALU_DIV = 4'd14;
   localparam logic [3:0] ALU_MOD = 4'd15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == ALU_DIV) || (op == ALU_MOD);
   endfunction

endpackage : RV32I_pkg
`default_nettype wire

// File: rtl/div_step_rv32i.sv
`default_nettype none
// ============================================================================
// Module      : div_step_rv32i
// Description : One radix-2 restoring division iteration (combinational).
//               The partial remainder shifts left taking the quotient MSB,
//               and the divisor is subtracted when it fits, which sets the
//               new quotient LSB.
// Ports       : i_rem     [WIDTH:0]    partial remainder in
//               i_q       [WIDTH-1:0]  quotient / dividend shift register in
//               i_divisor [WIDTH-1:0]  divisor magnitude
//               o_rem     [WIDTH:0]    partial remainder out
//               o_q       [WIDTH-1:0]  quotient shift register out
// Revision    : 1.0 - initial release
// ============================================================================
module div_step_rv32i #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   i_rem,
   input  logic [WIDTH-1:0] i_q,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH:0]   o_rem,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_divisor;
   logic [WIDTH:0] w_diff;

   always_comb begin
      // The extra remainder bit keeps the shifted value from wrapping when
      // the divisor magnitude is 2^(WIDTH-1).
      w_shift   = {i_rem[WIDTH-1:0], i_q[WIDTH-1]};
      w_divisor = {1'b0, i_divisor};
      w_diff    = w_shift - w_divisor;
      if (w_shift >= w_divisor) begin
         o_rem = w_diff;
         o_q   = {i_q[WIDTH-2:0], 1'b1};
      end else begin
         o_rem = w_shift;
         o_q   = {i_q[WIDTH-2:0], 1'b0};
      end
   end

endmodule : div_step_rv32i
`default_nettype wire

// File: rtl/div_unit_rv32i.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_rv32i
// Description : Iterative signed divide / remainder unit for the RV32I
//               execute stage. It runs restoring division on operand
//               magnitudes over WIDTH cycles, then applies a sign fix-up
//               cycle. Divide-by-zero and the signed overflow case finish
//               at acceptance.
// Ports       : clk          system clock, rising edge
//               rst          asynchronous active-high reset
//               start        request, sampled in IDLE or DONE
//               ALU_op [3:0] op code, 14 = div, 15 = mod
//               A  [WIDTH-1:0] dividend (two's complement)
//               B  [WIDTH-1:0] divisor  (two's complement)
//               flush        synchronous abort
//               busy         operation in flight, the pipeline stalls
//               done         one-cycle pulse, result valid
//               result [WIDTH-1:0] quotient or remainder
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit_rv32i
   import RV32I_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       ALU_op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] C_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] C_ONES    = {WIDTH{1'b1}};

   div_state_t       state_q,   state_d;
   logic             is_mod_q,  is_mod_d;
   logic             sign_a_q,  sign_a_d;
   logic             sign_b_q,  sign_b_d;
   logic [WIDTH-1:0] divisor_q, divisor_d;
   logic [WIDTH:0]   rem_q,     rem_d;
   logic [WIDTH-1:0] quo_q,     quo_d;
   logic [CW-1:0]    count_q,   count_d;
   logic             busy_q,    busy_d;
   logic             done_q,    done_d;
   logic [WIDTH-1:0] result_q,  result_d;

   logic [WIDTH:0]   w_step_rem;
   logic [WIDTH-1:0] w_step_quo;
   logic             w_accept;
   logic             w_div_zero;
   logic             w_overflow;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic [WIDTH-1:0] w_quo_fix;
   logic [WIDTH-1:0] w_rem_fix;

   div_step_rv32i #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_rem     (rem_q),
      .i_q       (quo_q),
      .i_divisor (divisor_q),
      .o_rem     (w_step_rem),
      .o_q       (w_step_quo)
   );

   always_comb begin
      // Flush blocks acceptance so a flushed request never loads anything.
      w_accept   = start && is_div_op(ALU_op) && !flush &&
                   ((state_q == IDLE) || (state_q == DONE));
      w_div_zero = (B == '0);
      w_overflow = (A == C_MIN_NEG) && (B == C_ONES);
      // The most negative value maps onto itself, which reads correctly
      // as an unsigned magnitude.
      w_abs_a    = A[WIDTH-1] ? -A : A;
      w_abs_b    = B[WIDTH-1] ? -B : B;
      w_quo_fix  = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
      w_rem_fix  = sign_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
   end

   always_comb begin
      state_d   = state_q;
      is_mod_d  = is_mod_q;
      sign_a_d  = sign_a_q;
      sign_b_d  = sign_b_q;
      divisor_d = divisor_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      count_d   = count_q;
      result_d  = result_q;

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (w_accept) begin
               is_mod_d  = (ALU_op == ALU_MOD);
               sign_a_d  = A[WIDTH-1];
               sign_b_d  = B[WIDTH-1];
               divisor_d = w_abs_b;
               rem_d     = '0;
               quo_d     = w_abs_a;
               count_d   = CW'(WIDTH - 1);
               if (w_div_zero) begin
                  result_d = (ALU_op == ALU_MOD) ? A : C_ONES;
                  state_d  = DONE;
               end else if (w_overflow) begin
                  result_d = (ALU_op == ALU_MOD) ? '0 : C_MIN_NEG;
                  state_d  = DONE;
               end else begin
                  state_d  = CALC;
               end
            end
         end
         CALC: begin
            rem_d = w_step_rem;
            quo_d = w_step_quo;
            if (count_q == '0) begin
               state_d = FIX;
            end else begin
               count_d = count_q - 1'b1;
            end
         end
         FIX: begin
            result_d = is_mod_q ? w_rem_fix : w_quo_fix;
            state_d  = DONE;
         end
         default: state_d = IDLE;
      endcase

      if (flush) begin
         state_d  = IDLE;
         result_d = result_q;
      end

      // Outputs are decodes of the next state so they come straight off flops.
      busy_d = (state_d == CALC) || (state_d == FIX);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         is_mod_q  <= 1'b0;
         sign_a_q  <= 1'b0;
         sign_b_q  <= 1'b0;
         divisor_q <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         count_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         is_mod_q  <= is_mod_d;
         sign_a_q  <= sign_a_d;
         sign_b_q  <= sign_b_d;
         divisor_q <= divisor_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         count_q   <= count_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         result_q  <= result_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule : div_unit_rv32i
`default_nettype wire

// File: tb/tb_div_unit_rv32i.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit_rv32i
// Description : Self-checking bench for div_unit_rv32i. A cycle-level
//               behavioural model computes results with native signed
//               division and tracks when busy/done must appear; a compare
//               process checks every cycle. Directed cases pin literal
//               results and latencies, followed by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit_rv32i;
   import RV32I_pkg::*;

   localparam int WIDTH = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  ALU_op;
   logic [31:0] A;
   logic [31:0] B;
   logic        flush;
   wire         busy;
   wire         done;
   wire  [31:0] result;

   div_unit_rv32i #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .ALU_op (ALU_op),
      .A      (A),
      .B      (B),
      .flush  (flush),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // ---------------- behavioural reference ----------------
   function automatic logic is_special(input logic [31:0] a, input logic [31:0] b);
      return (b == 32'h0) || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      int sa;
      int sb;
      sa = a;
      sb = b;
      if (b == 32'h0) return (op == ALU_DIV) ? 32'hFFFF_FFFF : a;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return (op == ALU_DIV) ? 32'h8000_0000 : 32'h0;
      return (op == ALU_DIV) ? 32'(sa / sb) : 32'(sa % sb);
   endfunction

   // m_left counts cycles still busy; zero means the unit can accept.
   int          m_left    = 0;
   logic        m_done    = 1'b0;
   logic [31:0] m_result  = 32'h0;
   logic [31:0] m_pending = 32'h0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left   = 0;
         m_done   = 1'b0;
         m_result = 32'h0;
      end else if (flush) begin
         m_left = 0;
         m_done = 1'b0;
      end else if (start && (ALU_op == ALU_DIV || ALU_op == ALU_MOD) && m_left == 0) begin
         if (is_special(A, B)) begin
            m_result = ref_res(ALU_op, A, B);
            m_done   = 1'b1;
         end else begin
            m_pending = ref_res(ALU_op, A, B);
            m_left    = WIDTH + 1;
            m_done    = 1'b0;
         end
      end else if (m_left > 0) begin
         m_left = m_left - 1;
         m_done = (m_left == 0);
         if (m_left == 0) m_result = m_pending;
      end else begin
         m_done = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("busy",   32'(busy), 32'(m_left > 0));
         chk("done",   32'(done), 32'(m_done));
         chk("result", result,    m_result);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      start  = 1'b1;
      ALU_op = op;
      A      = a;
      B      = b;
      tick();
      start  = 1'b0;
   endtask

   task automatic run_lit(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int c0;
      int lat;
      c0  = cyc;
      lat = -1;
      issue(op, a, b);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin
            lat = cyc - c0;
            break;
         end
      end
      chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
      chk(name, result, exp_res);
      tick();
   endtask

   function automatic logic [31:0] rand_operand();
      int r;
      r = $urandom_range(0, 9);
      case (r)
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         4:       return 32'(-$urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      flush  = 1'b0;
      ALU_op = 4'd0;
      A      = 32'h0;
      B      = 32'h0;
      repeat (2) tick();
      chk("reset_busy",   32'(busy), 32'h0);
      chk("reset_done",   32'(done), 32'h0);
      chk("reset_result", result,    32'h0);
      rst = 1'b0;
      tick();

      run_lit("div_100_7",     ALU_DIV, 32'd100,       32'd7,         32'd14,        34);
      run_lit("mod_m100_7",    ALU_MOD, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 34);
      run_lit("div_m100_7",    ALU_DIV, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 34);
      run_lit("div_by_zero",   ALU_DIV, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
      run_lit("mod_by_zero",   ALU_MOD, 32'd5,         32'd0,         32'd5,         1);
      run_lit("div_overflow",  ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_lit("mod_overflow",  ALU_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);

      // Back-to-back: second request is presented in the DONE cycle.
      issue(ALU_DIV, 32'd100, 32'd7);
      repeat (33) tick();
      chk("b2b_first_done", 32'(done), 32'h1);
      chk("b2b_first_res",  result,    32'd14);
      run_lit("b2b_second", ALU_MOD, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34);

      // Flush in cycle 10, then a new request in cycle 12.
      issue(ALU_DIV, 32'd1000, 32'd3);
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_busy",   32'(busy), 32'h0);
      chk("flush_done",   32'(done), 32'h0);
      chk("flush_result", result,    32'hFFFF_FFFE);
      tick();
      run_lit("after_flush_mod", ALU_MOD, 32'd17, 32'd5, 32'd2, 34);

      // Reset in cycle 20 of an operation.
      issue(ALU_DIV, 32'd12345, 32'd67);
      repeat (19) tick();
      rst = 1'b1;
      #1;
      chk("midrst_busy",   32'(busy), 32'h0);
      chk("midrst_done",   32'(done), 32'h0);
      chk("midrst_result", result,    32'h0);
      tick();
      rst = 1'b0;
      tick();
      issue(4'd2, 32'd9, 32'd3);
      repeat (5) tick();
      chk("badop_busy",   32'(busy), 32'h0);
      chk("badop_done",   32'(done), 32'h0);
      chk("badop_result", result,    32'h0);

      // Randomized traffic: requests at any time, illegal ops, flushes.
      for (int i = 0; i < 3000; i++) begin
         int r;
         start = ($urandom_range(0, 2) == 0);
         r     = $urandom_range(0, 7);
         if (r < 3)      ALU_op = ALU_DIV;
         else if (r < 6) ALU_op = ALU_MOD;
         else            ALU_op = 4'($urandom);
         A     = rand_operand();
         B     = rand_operand();
         flush = ($urandom_range(0, 59) == 0);
         tick();
      end
      start = 1'b0;
      flush = 1'b0;
      repeat (40) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_div_unit_rv32i
`default_nettype wire

// File: doc/div_unit_rv32i.md
# div_unit_rv32i

Iterative signed divide/remainder unit for the RV32I execute stage. It sits directly downstream of the ALU decoder and consumes its `ALU_op` codes 14 (div) and 15 (mod), which the single-cycle ALU does not complete. It runs a radix-2 restoring division over WIDTH iterations and raises `busy` so the hazard unit can stall the pipeline. On completion it pulses `done` with the 32-bit result.

## Interface
- `WIDTH`, 32: operand and result width.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `ALU_op`  in  4  op code from the ALU decoder; only 14 (div) and 15 (mod) are accepted.
- `A`  in  WIDTH  dividend, two's complement.
- `B`  in  WIDTH  divisor, two's complement.
- `flush`  in  1  synchronous abort, e.g. branch mispredict.
- `busy`  out  1  operation in flight; the pipeline must stall.
- `done`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  WIDTH  quotient (div) or remainder (mod).

## Operation
- Reset values: state = IDLE, `busy` = 0, `done` = 0, `result` = 0, internal registers = 0.
- States: IDLE, CALC, FIX, DONE.
- **Accept.** A request is accepted in IDLE or DONE when `start`=1 and `ALU_op` ∈ {14, 15}. On acceptance the unit latches the op, sign(A), sign(B), |A| and |B|, and sets count = WIDTH-1.
  - `start` with any other `ALU_op` is ignored.
  - `start` during CALC or FIX is ignored.
- **Special cases** are detected at acceptance and go straight to DONE:
  - B = 0: quotient = all-ones, remainder = A.
  - A = 0x80000000 and B = 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- **CALC.** Each cycle is one restoring step:
  - rem = {rem[WIDTH-2:0], q[WIDTH-1]}; q <<= 1.
  - If rem ≥ |B|, then rem -= |B| and q[0] = 1.
  - count decrements; on count = 0 the state goes to FIX.
- **FIX.** Sign correction:
  - The quotient is negated if sign(A) ≠ sign(B).
  - The remainder takes the sign of A.
  - The selected value is registered into `result`; state → DONE.
- **DONE.** `done` = 1 for one cycle. The state returns to IDLE unless a new request is accepted in the same cycle.
- `result` holds its value until the next FIX or special-case load.
- **Flush.** `flush` = 1 in any state sends the state to IDLE on the next edge and suppresses `done`. `result` is unchanged. `flush` takes priority over a simultaneous `start`.
- **Mid-operation reset.** The unit returns immediately to the reset values.
- Arithmetic:
  - Magnitudes are WIDTH-bit unsigned.
  - rem is WIDTH+1 bits so the compare/subtract cannot overflow.
  - |0x80000000| = 0x80000000 unsigned, which is correct.

## Timing
- Count `start` accepted in cycle 0.
- Normal case:
  - `busy` = 1 in cycles 1..WIDTH+1 (CALC is cycles 1..WIDTH, FIX is cycle WIDTH+1).
  - `done` = 1 in cycle WIDTH+2 (34 for WIDTH = 32), with `busy` = 0.
- Special case: `done` = 1 in cycle 1, and `busy` is never asserted.
- Back-to-back: `start` in the DONE cycle is accepted, so the next `done` arrives WIDTH+2 cycles later. There is no idle bubble.
- `busy` and `done` are registered state decodes, not functions of inputs.

## Structure
- The shared package `RV32I_pkg` holds:
  - the ALU op constants `ALU_DIV` = 4'd14 and `ALU_MOD` = 4'd15, identical to the decoder encoding;
  - the state enum `div_state_t` (IDLE, CALC, FIX, DONE).
- One combinational sub-module, `div_step_rv32i`, computes a single restoring iteration: in = rem, q, |B|; out = next rem, next q.

## Test plan
- div, A = 100, B = 7 → `busy` in cycles 1..33, `done` in cycle 34, `result` = 14.
- mod, A = -100, B = 7 → `result` = 0xFFFFFFFE (-2); div with the same operands → 0xFFFFFFF2 (-14).
- B = 0 with A = 5 → div gives 0xFFFFFFFF in cycle 1, mod gives 5; `busy` is never high.
- div, A = 0x80000000, B = 0xFFFFFFFF → `result` = 0x80000000 in cycle 1; mod → 0.
- `flush` in cycle 10 of a div → IDLE at cycle 11 with no `done` and `result` unchanged. A new request (mod, A = 17, B = 5) accepted in cycle 12 → `done` in cycle 46, `result` = 2.
- `rst` asserted in cycle 20 of an operation → `busy`, `done` and `result` go to 0 immediately. `start` with `ALU_op` = 2 → no response.
